sort4_ctrl: RTL and testbench
=============================

# sort4_ctrl

Sequential sorting controller that orders four 4-bit values in ascending order by time-sharing a single `comparator_4b` instance, one compare-and-swap per clock. It sits between a producer that supplies a packed 16-bit word and a consumer that needs the sorted word, and replaces four parallel comparators plus a sorting network. A start/busy/done handshake sequences it, and it reports how many swaps it performed.

## Interface
- No parameters. Element width (4) and element count (4) are fixed by the shared `comparator_4b`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to sort `din`; sampled only while `busy`=0.
- `din`  in  16  packed input: element e0=`din[3:0]`, e1=`din[7:4]`, e2=`din[11:8]`, e3=`din[15:12]`.
- `busy`  out  1  high while compare-and-swap steps are in progress.
- `done`  out  1  one-cycle pulse when `dout` and `swaps` update.
- `dout`  out  16  sorted result, same packing as `din`; e0 is smallest and e3 is largest.
- `swaps`  out  3  number of swaps performed in the last completed sort, range 0..6.

## Operation
- Working registers w0..w3 (4 bits each), step counter (0..5), swap counter (3 bits), and FSM states IDLE, SORT, DONE.
- One `comparator_4b` is instantiated. Its operands are selected by a mux from the pair indexed by the step counter: num1=w[i], num2=w[i+1].
- Fixed schedule (bubble sort, 6 steps): step0 (0,1), step1 (1,2), step2 (2,3), step3 (0,1), step4 (1,2), step5 (0,1).
- Per step: if `gto`=1, swap w[i] and w[i+1] and increment the swap counter. If `eqo`=1 or `lto`=1, there is no change. Equal elements are never swapped.
- IDLE or DONE with `start`=1:
  - load w0..w3 from `din`;
  - clear the step and swap counters;
  - go to SORT.
- IDLE or DONE with `start`=0: go to (or stay in) IDLE.
- SORT:
  - perform the current step;
  - if step=5, go to DONE; otherwise increment step.
- Entering DONE: register `dout` from the final w values and `swaps` from the swap counter.
- `start` while `busy`=1 is ignored. No queueing and no restart.
- `dout` and `swaps` hold their values until the next transition into DONE.
- Reset (any state, including mid-SORT):
  - state IDLE;
  - `busy`=0, `done`=0, `dout`=16'h0000, `swaps`=3'd0;
  - working registers and counters cleared;
  - an aborted sort produces no `done`.

## Timing
- `start` is sampled high at the edge ending cycle k, with `busy`=0.
- Cycles k+1..k+6: `busy`=1, with steps 0..5 performed one per cycle.
- Cycle k+7: `done`=1, `busy`=0, and `dout`/`swaps` are valid. Latency from `start` to `done` is 7 cycles.
- `start` in the DONE cycle (k+7) is accepted. Back-to-back sorts can issue every 7 cycles.
- `done` is exactly 1 cycle wide.
- `busy` is 1 only in the SORT state.
- All outputs are registered, so there is no combinational path from `start` or `din` to any output.

## Test plan
- Reset, then `din`=16'h1234 and `start` pulse:
  - `busy` is high for 6 cycles;
  - `done` is high at k+7;
  - `dout`=16'h4321, `swaps`=6.
- Already sorted, `din`=16'h4321: `dout`=16'h4321, `swaps`=0.
- All equal, `din`=16'h7777: `dout`=16'h7777, `swaps`=0.
- `din`=16'h0F0F: `dout`=16'hFF00, `swaps`=3.
- Busy/back-to-back behaviour:
  - start 16'h1234;
  - pulse `start` with `din`=16'h0F0F at k+3: ignored, result is still 16'h4321/6;
  - assert `start` with 16'h0F0F in the `done` cycle: second `done` exactly 7 cycles later with 16'hFF00/3.
- Reset mid-operation:
  - start 16'h1234;
  - assert `rst` at k+4: all outputs are 0 the next cycle and no `done` follows;
  - a new start with 16'h4321 completes normally.

Source files
------------

// File: rtl/sort4_ctrl.sv
// Sequential 4-element ascending sorter: one shared 4-bit comparator, one
// bubble-sort compare-and-swap per clock, start/busy/done handshake.

module comparator_4b (
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  output logic       gto,
  output logic       eqo,
  output logic       lto
);
  assign gto = (num1 >  num2);
  assign eqo = (num1 == num2);
  assign lto = (num1 <  num2);
endmodule

module sort4_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] din,
  output logic        busy,
  output logic        done,
  output logic [15:0] dout,
  output logic [2:0]  swaps
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [3:0][3:0] w;
  logic [2:0]      step;
  logic [2:0]      swap_cnt;

  logic [1:0]      idx_lo;
  logic [1:0]      idx_hi;
  logic [3:0][3:0] w_nxt;
  logic [2:0]      swap_cnt_nxt;
  logic            gto;
  logic            eqo;
  logic            lto;

  // Bubble schedule: pairs (0,1) (1,2) (2,3) (0,1) (1,2) (0,1).
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    idx_lo = 2'd0;
    case (step)
      3'd1, 3'd4: idx_lo = 2'd1;
      3'd2:       idx_lo = 2'd2;
      default:    idx_lo = 2'd0;
    endcase
    idx_hi = idx_lo + 2'd1;
  end

  comparator_4b u_cmp (
    .num1 (w[idx_lo]),
    .num2 (w[idx_hi]),
    .gto  (gto),
    .eqo  (eqo),
    .lto  (lto)
  );

  // Only a strict greater-than swaps, so equal elements keep their order.
  always_comb begin
    w_nxt        = w;
    swap_cnt_nxt = swap_cnt;
    if (gto && !eqo && !lto) begin
      w_nxt[idx_lo] = w[idx_hi];
      w_nxt[idx_hi] = w[idx_lo];
      swap_cnt_nxt  = swap_cnt + 3'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      w        <= '0;
      step     <= 3'd0;
      swap_cnt <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= 16'h0000;
      swaps    <= 3'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            w        <= din;
            step     <= 3'd0;
            swap_cnt <= 3'd0;
            busy     <= 1'b1;
            state    <= SORT;
          end else begin
            state <= IDLE;
          end
        end
        SORT: begin
          w        <= w_nxt;
          swap_cnt <= swap_cnt_nxt;
          if (step == 3'd5) begin
            // Results come from the post-swap values of the last step.
            dout  <= w_nxt;
            swaps <= swap_cnt_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            step <= step + 3'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed bench for sort4_ctrl: reset, sort vectors, busy/back-to-back
// handshake and reset abort, with hand-computed expected results.

module tb_sort4_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [15:0] dout;
  logic [2:0]  swaps;

  int n_checks = 0;
  int n_fail   = 0;

  sort4_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .swaps (swaps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold start high for one cycle; returns positioned in cycle k+1.
  task automatic pulse_start(input logic [15:0] value);
    din   = value;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    din   = 16'h0000;
    step_cycle();
    step_cycle();
    n_checks++;
    if ({busy, done, dout, swaps} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b dout=%h swaps=%0d, required all 0",
               busy, done, dout, swaps);
    end
    rst = 1'b0;
    step_cycle();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0/0", busy, done);
    end
  endtask

  task automatic test_sort(input string name, input logic [15:0] value,
                           input logic [15:0] exp_dout, input logic [2:0] exp_swaps);
    int busy_bad;
    busy_bad = 0;
    pulse_start(value);
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      step_cycle();
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy_window: %0d of 6 cycles not busy=1/done=0, required 0", name, busy_bad);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_at_k7: done=%b busy=%b, required 1/0", name, done, busy);
    end
    n_checks++;
    if (dout !== exp_dout || swaps !== exp_swaps) begin
      n_fail++;
      $display("FAIL %s result: dout=%h swaps=%0d, required %h/%0d",
               name, dout, swaps, exp_dout, exp_swaps);
    end
    step_cycle();
    n_checks++;
    if (done !== 1'b0 || dout !== exp_dout || swaps !== exp_swaps) begin
      n_fail++;
      $display("FAIL %s done_width_hold: done=%b dout=%h swaps=%0d, required 0/%h/%0d",
               name, done, dout, swaps, exp_dout, exp_swaps);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start(16'h1234);             // now in k+1
    step_cycle();
    step_cycle();                      // k+3
    din   = 16'h0F0F;
    start = 1'b1;
    step_cycle();                      // k+4
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ignored_start_busy: busy=%b, required 1", busy);
    end
    step_cycle();
    step_cycle();
    step_cycle();                      // k+7
    n_checks++;
    if (done !== 1'b1 || dout !== 16'h4321 || swaps !== 3'd6) begin
      n_fail++;
      $display("FAIL b2b_first_result: done=%b dout=%h swaps=%0d, required 1/4321/6",
               done, dout, swaps);
    end
    pulse_start(16'h0F0F);             // accepted in the done cycle, now k+8
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart_busy: busy=%b done=%b, required 1/0", busy, done);
    end
    for (int i = 0; i < 6; i++) step_cycle();  // k+14
    n_checks++;
    if (done !== 1'b1 || dout !== 16'hFF00 || swaps !== 3'd3) begin
      n_fail++;
      $display("FAIL b2b_second_result: done=%b dout=%h swaps=%0d, required 1/ff00/3",
               done, dout, swaps);
    end
    step_cycle();
  endtask

  task automatic test_reset_mid_sort();
    int done_seen;
    done_seen = 0;
    pulse_start(16'h1234);             // k+1
    step_cycle();
    step_cycle();
    step_cycle();                      // k+4
    rst = 1'b1;
    step_cycle();                      // k+5
    n_checks++;
    if ({busy, done, dout, swaps} !== 21'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%b done=%b dout=%h swaps=%0d, required all 0",
               busy, done, dout, swaps);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
      step_cycle();
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d cycles with done/busy set, required 0", done_seen);
    end
    test_sort("after_abort", 16'h4321, 16'h4321, 3'd0);
  endtask

  initial begin
    test_reset();
    test_sort("reverse",   16'h1234, 16'h4321, 3'd6);
    test_sort("sorted",    16'h4321, 16'h4321, 3'd0);
    test_sort("all_equal", 16'h7777, 16'h7777, 3'd0);
    test_sort("mixed",     16'h0F0F, 16'hFF00, 3'd3);
    test_sort("dups",      16'h2A2A, 16'hAA22, 3'd3);
    test_back_to_back();
    test_reset_mid_sort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit, required finish");
    $fatal(1, "timeout");
  end

endmodule
